// File: rtl/count_pkg.sv
// count_pkg: shared state encodings, BCD constants and index-width helper for count_sequencer
package count_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SELECT  = 2'd1;
  localparam logic [1:0] CARRY   = 2'd2;
  localparam logic [1:0] REFRESH = 2'd3;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lsb_index_encoder.sv
// lsb_index_encoder: index of the lowest set bit of vec, with valid when any bit is set
module lsb_index_encoder
  import count_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic [DIGITS-1:0]            vec,
  output logic [idx_w(DIGITS)-1:0]     idx,
  output logic                         valid
);
  localparam int KW = idx_w(DIGITS);
  assign valid = |vec;
  // scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      if (vec[i]) idx = KW'(i);
  end
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: applies per-decade BCD increments with rippling carries, then issues one refresh pulse
module count_sequencer
  import count_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc_pulse,
  input  logic [DIGITS-1:0]       trigger,
  input  logic                    clear,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    ref_pulse,
  output logic                    busy,
  output logic                    overflow,
  output logic                    dropped
);
  localparam int KW = idx_w(DIGITS);
  localparam logic [KW-1:0] TOP = KW'(DIGITS - 1);
  logic [1:0]        state, nxt;
  logic [DIGITS-1:0] pending;
  logic [KW-1:0]     k, lsb_idx;
  logic              lsb_valid;
  logic [BCD_W-1:0]  digit;
  logic              wrap;
  assign digit = count[BCD_W*k +: BCD_W];
  // codes 10..15 cannot occur normally; if they do, they roll over like 9
  assign wrap  = digit >= BCD_MAX;
  lsb_index_encoder #(.DIGITS(DIGITS)) u_lsb (
    .vec   (pending),
    .idx   (lsb_idx),
    .valid (lsb_valid)
  );
  // next-state decode; clear takes priority over an increment in IDLE
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = clear ? REFRESH : (inc_pulse && |trigger) ? SELECT : IDLE;
      SELECT:  nxt = lsb_valid ? CARRY : REFRESH;
      CARRY:   nxt = (wrap && k != TOP) ? CARRY : SELECT;
      default: nxt = IDLE;
    endcase
  end
  // state, registered status outputs, pending mask and the BCD count itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ref_pulse <= 1'b0;
      dropped   <= 1'b0;
      overflow  <= 1'b0;
      pending   <= '0;
      k         <= '0;
      count     <= '0;
    end else begin
      state     <= nxt;
      busy      <= nxt != IDLE;
      ref_pulse <= nxt == REFRESH;
      dropped   <= (state == IDLE) ? (clear & inc_pulse) : (clear | inc_pulse);
      case (state)
        IDLE: begin
          if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
          end else if (inc_pulse && |trigger) begin
            pending <= trigger;
          end
        end
        SELECT: begin
          if (lsb_valid) begin
            k                <= lsb_idx;
            pending[lsb_idx] <= 1'b0;
          end
        end
        CARRY: begin
          if (wrap) begin
            count[BCD_W*k +: BCD_W] <= '0;
            if (k != TOP) k <= k + KW'(1);
            else overflow <= 1'b1;
          end else begin
            count[BCD_W*k +: BCD_W] <= digit + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed scoreboard bench for count_sequencer
module tb_count_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inc_pulse = 1'b0;
  logic [5:0]  trigger = '0;
  logic        clear = 1'b0;
  logic [23:0] count;
  logic        ref_pulse, busy, overflow, dropped;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [24:0] sb[$];

  count_sequencer #(.DIGITS(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .inc_pulse (inc_pulse),
    .trigger   (trigger),
    .clear     (clear),
    .count     (count),
    .ref_pulse (ref_pulse),
    .busy      (busy),
    .overflow  (overflow),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every refresh must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ref_pulse) begin
      if (sb.size() == 0) begin
        check("unexpected_ref", 32'd1, 32'd0);
      end else begin
        logic [24:0] e;
        e = sb.pop_front();
        check("ref_count", {8'd0, count}, {8'd0, e[24:1]});
        check("ref_overflow", {31'd0, overflow}, {31'd0, e[0]});
      end
    end
  end

  task automatic send(input logic inc, input logic [5:0] trig, input logic clr,
                      input logic [23:0] ec, input logic eo, input int lat, input string tag);
    int n, bc;
    @(negedge clk);
    inc_pulse = inc;
    trigger   = trig;
    clear     = clr;
    sb.push_back({ec, eo});
    @(negedge clk);
    inc_pulse = 1'b0;
    trigger   = '0;
    clear     = 1'b0;
    n  = 1;
    bc = 0;
    while (1) begin
      if (busy) bc++;
      if (ref_pulse || n >= 200) break;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, bc, lat);
    @(negedge clk);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_count", {8'd0, count}, 32'd0);
    check("rst_flags", {28'd0, ref_pulse, busy, overflow, dropped}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    send(1'b1, 6'b000001, 1'b0, 24'h000001, 1'b0, 4, "single");
    send(1'b0, 6'b000000, 1'b1, 24'h000000, 1'b0, 1, "clear1");
    for (int i = 1; i <= 9; i++)
      send(1'b1, 6'b000111, 1'b0, {12'h000, 4'(i), 4'(i), 4'(i)}, 1'b0, 8, "build999");
    send(1'b1, 6'b000001, 1'b0, 24'h001000, 1'b0, 7, "ripple");
    send(1'b0, 6'b000000, 1'b1, 24'h000000, 1'b0, 1, "clear2");
    for (int i = 1; i <= 9; i++)
      send(1'b1, 6'b000001, 1'b0, {20'h00000, 4'(i)}, 1'b0, 4, "build9");
    send(1'b1, 6'b000011, 1'b0, 24'h000020, 1'b0, 7, "simul");
    // inc_pulse while in CARRY must be dropped and leave count untouched
    @(negedge clk);
    inc_pulse = 1'b1;
    trigger   = 6'b000001;
    sb.push_back({24'h000021, 1'b0});
    @(negedge clk);
    inc_pulse = 1'b0;
    trigger   = '0;
    check("coll_dropped_c1", {31'd0, dropped}, 32'd0);
    @(negedge clk);
    inc_pulse = 1'b1;
    trigger   = 6'b100000;
    check("coll_busy_c2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    inc_pulse = 1'b0;
    trigger   = '0;
    check("coll_dropped_c3", {31'd0, dropped}, 32'd1);
    @(negedge clk);
    check("coll_dropped_c4", {31'd0, dropped}, 32'd0);
    check("coll_ref_c4", {31'd0, ref_pulse}, 32'd1);
    @(negedge clk);
    check("coll_idle", {31'd0, busy}, 32'd0);
    check("coll_count", {8'd0, count}, 32'h000021);
    // clear with inc_pulse in IDLE: clear wins, the increment is dropped
    @(negedge clk);
    clear     = 1'b1;
    inc_pulse = 1'b1;
    trigger   = 6'b000001;
    sb.push_back({24'h000000, 1'b0});
    @(negedge clk);
    clear     = 1'b0;
    inc_pulse = 1'b0;
    trigger   = '0;
    check("clrinc_dropped", {31'd0, dropped}, 32'd1);
    check("clrinc_ref", {31'd0, ref_pulse}, 32'd1);
    @(negedge clk);
    check("clrinc_dropped_gone", {31'd0, dropped}, 32'd0);
    check("clrinc_idle", {31'd0, busy}, 32'd0);
    for (int i = 1; i <= 9; i++)
      send(1'b1, 6'b111111, 1'b0, {6{4'(i)}}, 1'b0, 14, "build999999");
    send(1'b1, 6'b000001, 1'b0, 24'h000000, 1'b1, 9, "overflow");
    send(1'b1, 6'b000001, 1'b0, 24'h000001, 1'b1, 4, "ovf_sticky");
    send(1'b0, 6'b000000, 1'b1, 24'h000000, 1'b0, 1, "ovf_clear");
    send(1'b1, 6'b100000, 1'b0, 24'h100000, 1'b0, 4, "top_digit");
    // reset in CARRY aborts without a refresh
    @(negedge clk);
    inc_pulse = 1'b1;
    trigger   = 6'b000001;
    @(negedge clk);
    inc_pulse = 1'b0;
    trigger   = '0;
    @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_count", {8'd0, count}, 32'd0);
    check("async_flags", {28'd0, ref_pulse, busy, overflow, dropped}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_count", {8'd0, count}, 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
